// File: rtl/dma_pkg.sv
// dma_pkg: shared encodings for the DMA transfer controller.
//   - instruction codes for the 3-bit instruction stream
//   - control register field positions and done-mode encodings
package dma_pkg;

  typedef enum logic [2:0] {
    WRCR   = 3'd0,
    RDCR   = 3'd1,
    RDWC   = 3'd2,
    RDAC   = 3'd3,
    REINIT = 3'd4,
    LDADDR = 3'd5,
    LDWC   = 3'd6,
    ENCT   = 3'd7
  } instr_e;

  // cr[2] = address direction, cr[1:0] = done mode
  localparam int CR_DIR      = 2;
  localparam int CR_MODE_MSB = 1;
  localparam int CR_MODE_LSB = 0;

  typedef enum logic [1:0] {
    MODE_WC_DOWN  = 2'b00,
    MODE_WC_UP    = 2'b01,
    MODE_ADDR_CMP = 2'b10,
    MODE_FREE     = 2'b11
  } mode_e;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// dma_xfer_ctrl_if: sequencer/bus-side signal bundle of the DMA transfer
// controller.
//   master: drives instr, instr_valid, data_in, xfer (microcode sequencer)
//   slave : drives data_out, rd_valid, addr_out, addr_co, done, run
//           (and irq when DMA_DONE_IRQ_EN is defined)
interface dma_xfer_ctrl_if #(parameter int W = 8);
  logic [2:0]   instr;
  logic         instr_valid;
  logic [W-1:0] data_in;
  logic         xfer;
  logic [W-1:0] data_out;
  logic         rd_valid;
  logic [W-1:0] addr_out;
  logic         addr_co;
  logic         done;
  logic         run;
`ifdef DMA_DONE_IRQ_EN
  logic         irq;

  modport master (output instr, instr_valid, data_in, xfer,
                  input  data_out, rd_valid, addr_out, addr_co, done, run, irq);
  modport slave  (input  instr, instr_valid, data_in, xfer,
                  output data_out, rd_valid, addr_out, addr_co, done, run, irq);
`else
  modport master (output instr, instr_valid, data_in, xfer,
                  input  data_out, rd_valid, addr_out, addr_co, done, run);
  modport slave  (input  instr, instr_valid, data_in, xfer,
                  output data_out, rd_valid, addr_out, addr_co, done, run);
`endif
endinterface

// File: rtl/dma_term_detect.sv
// dma_term_detect: combinational step evaluation.
//   in : cr (direction + done mode), wc, addr (current counter values)
//   out: addr_nxt / wc_nxt (values after one step), addr_co (wrap on this
//        step), term (this step reaches the terminal condition)
module dma_term_detect
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   cr,
  input  logic [W-1:0] wc,
  input  logic [W-1:0] addr,
  output logic [W-1:0] addr_nxt,
  output logic [W-1:0] wc_nxt,
  output logic         addr_co,
  output logic         term
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ALL1 = '1;

  mode_e mode;

  always_comb begin
    mode = mode_e'(cr[CR_MODE_MSB:CR_MODE_LSB]);

    if (cr[CR_DIR]) begin
      addr_nxt = addr - ONE;
      addr_co  = (addr == '0);
    end else begin
      addr_nxt = addr + ONE;
      addr_co  = (addr == ALL1);
    end

    wc_nxt = wc;
    term   = 1'b0;
    case (mode)
      // terminal on the step that lands on zero, so wc=0 runs 2^W steps
      MODE_WC_DOWN: begin
        wc_nxt = wc - ONE;
        term   = (wc_nxt == '0);
      end
      MODE_WC_UP: begin
        wc_nxt = wc + ONE;
        term   = (wc_nxt == ALL1);
      end
      // wc holds the end address and is not stepped
      MODE_ADDR_CMP: begin
        term = (addr_nxt == wc);
      end
      default: begin
        wc_nxt = wc - ONE;
      end
    endcase
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: transfer-side DMA address/word counter controller.
//   clk : system clock, rising-edge updates
//   res : asynchronous active-high reset
//   bus : dma_xfer_ctrl_if.slave (instructions, xfer, readback, counters)
// Optional: define DMA_DONE_IRQ_EN to add the sticky bus.irq output.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             res,
  dma_xfer_ctrl_if.slave   bus
);

  logic [2:0]   cr_q, cr_d;
  logic [W-1:0] addr_q, addr_d, addr_init_q, addr_init_d;
  logic [W-1:0] wc_q, wc_d, wc_init_q, wc_init_d;
  logic [W-1:0] data_out_q, data_out_d;
  logic         run_q, run_d, done_q, done_d;
  logic         rd_valid_q, rd_valid_d, addr_co_q, addr_co_d;
  logic         irq_q, irq_d;

  logic [W-1:0] addr_nxt, wc_nxt;
  logic         step_co, step_term;
  logic         step, load_ovr;
  instr_e       op;

  dma_term_detect #(.W(W)) u_term (
    .cr       (cr_q),
    .wc       (wc_q),
    .addr     (addr_q),
    .addr_nxt (addr_nxt),
    .wc_nxt   (wc_nxt),
    .addr_co  (step_co),
    .term     (step_term)
  );

  always_comb begin
    op          = instr_e'(bus.instr);
    cr_d        = cr_q;
    addr_d      = addr_q;
    addr_init_d = addr_init_q;
    wc_d        = wc_q;
    wc_init_d   = wc_init_q;
    data_out_d  = data_out_q;
    run_d       = run_q;
    done_d      = done_q;
    rd_valid_d  = 1'b0;
    addr_co_d   = 1'b0;
    irq_d       = irq_q;

    step     = bus.xfer & run_q & ~done_q;
    // loads discard a same-cycle step entirely, including its carry
    load_ovr = bus.instr_valid &&
               (op == REINIT || op == LDADDR || op == LDWC);

    if (step && !load_ovr) begin
      addr_d    = addr_nxt;
      wc_d      = wc_nxt;
      addr_co_d = step_co;
      if (step_term) begin
        done_d = 1'b1;
        run_d  = 1'b0;
      end
    end

    if (bus.instr_valid) begin
      case (op)
        WRCR:   cr_d = bus.data_in[2:0];
        RDCR: begin
          data_out_d = W'(cr_q);
          rd_valid_d = 1'b1;
        end
        RDWC: begin
          data_out_d = wc_q;
          rd_valid_d = 1'b1;
        end
        RDAC: begin
          data_out_d = addr_q;
          rd_valid_d = 1'b1;
        end
        REINIT: begin
          addr_d = addr_init_q;
          wc_d   = wc_init_q;
          done_d = 1'b0;
          run_d  = 1'b0;
        end
        LDADDR: begin
          addr_d      = bus.data_in;
          addr_init_d = bus.data_in;
        end
        LDWC: begin
          wc_d      = bus.data_in;
          wc_init_d = bus.data_in;
        end
        // a terminal step in the same cycle also blocks the enable
        ENCT:   if (!done_d) run_d = 1'b1;
        default: ;
      endcase
    end

    irq_d = irq_q | (done_d & ~done_q);
    if (bus.instr_valid && op == REINIT) irq_d = 1'b0;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cr_q        <= 3'b000;
      addr_q      <= '0;
      addr_init_q <= '0;
      wc_q        <= '0;
      wc_init_q   <= '0;
      data_out_q  <= '0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      addr_co_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      cr_q        <= cr_d;
      addr_q      <= addr_d;
      addr_init_q <= addr_init_d;
      wc_q        <= wc_d;
      wc_init_q   <= wc_init_d;
      data_out_q  <= data_out_d;
      run_q       <= run_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      addr_co_q   <= addr_co_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_out = addr_q;
  assign bus.addr_co  = addr_co_q;
  assign bus.done     = done_q;
  assign bus.run      = run_q;
`ifdef DMA_DONE_IRQ_EN
  assign bus.irq      = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b1;

  dma_xfer_ctrl_if #(.W(8)) bus ();

  dma_xfer_ctrl #(.W(8)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] ins;
    logic [7:0] d;
    logic       x;
    logic [7:0] rd;
    logic [7:0] addr;
    logic       done;
    logic       run;
    logic       co;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] ins, input logic [7:0] d,
                     input logic x, input logic [7:0] rd, input logic [7:0] addr,
                     input logic done, input logic run, input logic co);
    vec_t r;
    r.v = v; r.ins = ins; r.d = d; r.x = x; r.rd = rd;
    r.addr = addr; r.done = done; r.run = run; r.co = co;
    vt.push_back(r);
  endtask

  // one clock: drive on negedge, sample 1 time unit after the rising edge
  task automatic cyc(input logic v, input logic [2:0] ins, input logic [7:0] d,
                     input logic x, input logic [7:0] rd);
    logic is_rd;
    @(negedge clk);
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.data_in     = d;
    bus.xfer        = x;
    is_rd = v && (ins == RDCR || ins == RDWC || ins == RDAC);
    if (is_rd) exp_q.push_back(rd);
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, is_rd});
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("data_out", {24'b0, bus.data_out}, {24'b0, exp_q.pop_front()});
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] addr,
                           input logic done, input logic run, input logic co);
    chk({tag, ".addr"}, {24'b0, bus.addr_out}, {24'b0, addr});
    chk({tag, ".done"}, {31'b0, bus.done}, {31'b0, done});
    chk({tag, ".run"},  {31'b0, bus.run},  {31'b0, run});
    chk({tag, ".co"},   {31'b0, bus.addr_co}, {31'b0, co});
  endtask

  initial begin
    logic irq_m, prev_done;
    bus.instr_valid = 1'b0;
    bus.instr       = 3'd0;
    bus.data_in     = 8'd0;
    bus.xfer        = 1'b0;

    // v ins d x rd | addr done run co
    add(1, WRCR,   8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, LDADDR, 8'h10, 0, 8'h00, 8'h10, 0, 0, 0);
    add(1, LDWC,   8'h03, 0, 8'h00, 8'h10, 0, 0, 0);
    add(1, ENCT,   8'h00, 0, 8'h00, 8'h10, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h11, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h12, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h13, 1, 0, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h13, 1, 0, 0);
    add(1, ENCT,   8'h00, 0, 8'h00, 8'h13, 1, 0, 0);
    add(1, REINIT, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0);
    add(1, RDWC,   8'h00, 0, 8'h03, 8'h10, 0, 0, 0);
    add(1, RDAC,   8'h00, 0, 8'h10, 8'h10, 0, 0, 0);
    add(1, RDCR,   8'h00, 0, 8'h00, 8'h10, 0, 0, 0);
    // decrement with borrow
    add(1, WRCR,   8'h04, 0, 8'h00, 8'h10, 0, 0, 0);
    add(1, LDADDR, 8'h01, 0, 8'h00, 8'h01, 0, 0, 0);
    add(1, LDWC,   8'h05, 0, 8'h00, 8'h01, 0, 0, 0);
    add(1, ENCT,   8'h00, 0, 8'h00, 8'h01, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h00, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'hFF, 0, 1, 1);
    add(0, WRCR,   8'h00, 0, 8'h00, 8'hFF, 0, 1, 0);
    add(1, RDWC,   8'h00, 0, 8'h03, 8'hFF, 0, 1, 0);
    add(1, RDCR,   8'h00, 0, 8'h04, 8'hFF, 0, 1, 0);
    // address compare
    add(1, REINIT, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0);
    add(1, WRCR,   8'h02, 0, 8'h00, 8'h01, 0, 0, 0);
    add(1, LDADDR, 8'hFD, 0, 8'h00, 8'hFD, 0, 0, 0);
    add(1, LDWC,   8'h00, 0, 8'h00, 8'hFD, 0, 0, 0);
    add(1, ENCT,   8'h00, 0, 8'h00, 8'hFD, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'hFE, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'hFF, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h00, 1, 0, 1);
    add(0, WRCR,   8'h00, 0, 8'h00, 8'h00, 1, 0, 0);
    add(1, RDWC,   8'h00, 0, 8'h00, 8'h00, 1, 0, 0);
    // load/step collision and cr-before-edge
    add(1, REINIT, 8'h00, 0, 8'h00, 8'hFD, 0, 0, 0);
    add(1, WRCR,   8'h00, 0, 8'h00, 8'hFD, 0, 0, 0);
    add(1, LDADDR, 8'h20, 0, 8'h00, 8'h20, 0, 0, 0);
    add(1, LDWC,   8'h10, 0, 8'h00, 8'h20, 0, 0, 0);
    add(1, ENCT,   8'h00, 0, 8'h00, 8'h20, 0, 1, 0);
    add(1, LDADDR, 8'h40, 1, 8'h00, 8'h40, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h41, 0, 1, 0);
    add(1, WRCR,   8'h04, 1, 8'h00, 8'h42, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h41, 0, 1, 0);
    add(1, RDAC,   8'h00, 1, 8'h41, 8'h40, 0, 1, 0);
    add(0, LDADDR, 8'h99, 0, 8'h00, 8'h40, 0, 1, 0);
    // word count up
    add(1, REINIT, 8'h00, 0, 8'h00, 8'h40, 0, 0, 0);
    add(1, WRCR,   8'h01, 0, 8'h00, 8'h40, 0, 0, 0);
    add(1, LDWC,   8'hFD, 0, 8'h00, 8'h40, 0, 0, 0);
    add(1, ENCT,   8'h00, 0, 8'h00, 8'h40, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h41, 0, 1, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h42, 1, 0, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h42, 1, 0, 0);
    add(1, RDWC,   8'h00, 0, 8'hFF, 8'h42, 1, 0, 0);
    // xfer with run=0
    add(1, REINIT, 8'h00, 0, 8'h00, 8'h40, 0, 0, 0);
    add(0, WRCR,   8'h00, 1, 8'h00, 8'h40, 0, 0, 0);

    // reset state (held in reset, then after release)
    repeat (2) @(posedge clk);
    #1;
    chk_state("in_reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #1;
    chk_state("reset", 8'h00, 0, 0, 0);
    chk("reset.rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("reset.data_out", {24'b0, bus.data_out}, 32'd0);
`ifdef DMA_DONE_IRQ_EN
    chk("reset.irq", {31'b0, bus.irq}, 32'd0);
`endif

    irq_m = 1'b0;
    prev_done = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].v, vt[i].ins, vt[i].d, vt[i].x, vt[i].rd);
      chk_state($sformatf("row%0d", i), vt[i].addr, vt[i].done, vt[i].run, vt[i].co);
      if (vt[i].v && vt[i].ins == REINIT) irq_m = 1'b0;
      else irq_m = irq_m | (vt[i].done & ~prev_done);
      prev_done = vt[i].done;
`ifdef DMA_DONE_IRQ_EN
      chk($sformatf("row%0d.irq", i), {31'b0, bus.irq}, {31'b0, irq_m});
`endif
    end

    // async reset mid-transfer, between edges
    cyc(1, ENCT, 8'h00, 0, 8'h00);
    cyc(0, WRCR, 8'h00, 1, 8'h00);
    chk_state("pre_reset", 8'h41, 0, 1, 0);
    @(negedge clk);
    bus.xfer = 1'b1;
    #2;
    res = 1'b1;
    #1;
    chk_state("async_reset", 8'h00, 0, 0, 0);
    chk("async_reset.data_out", {24'b0, bus.data_out}, 32'd0);
    chk("async_reset.rd_valid", {31'b0, bus.rd_valid}, 32'd0);
`ifdef DMA_DONE_IRQ_EN
    chk("async_reset.irq", {31'b0, bus.irq}, 32'd0);
`endif
    #1;
    res = 1'b0;
    bus.xfer = 1'b0;

    // wc=0 from reset: 2^W transfers before done
    cyc(1, RDCR, 8'h00, 0, 8'h00);
    cyc(1, RDWC, 8'h00, 0, 8'h00);
    cyc(1, ENCT, 8'h00, 0, 8'h00);
    chk_state("wc0_start", 8'h00, 0, 1, 0);
    for (int n = 0; n < 255; n++) cyc(0, WRCR, 8'h00, 1, 8'h00);
    chk_state("wc0_255", 8'hFF, 0, 1, 0);
    cyc(0, WRCR, 8'h00, 1, 8'h00);
    chk_state("wc0_256", 8'h00, 1, 0, 1);
`ifdef DMA_DONE_IRQ_EN
    chk("wc0.irq_set", {31'b0, bus.irq}, 32'd1);
    cyc(1, REINIT, 8'h00, 0, 8'h00);
    chk("wc0.irq_clr", {31'b0, bus.irq}, 32'd0);
`endif
    cyc(0, WRCR, 8'h00, 0, 8'h00);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
